// File: rtl/approx_mult_error_accumulator.sv
// approx_mult_error_accumulator: accumulates ED = |exact - approx| count/sum/max over a programmed run.
// Define ERR_MAX_TRACK_EN to build max_ed tracking; otherwise max_ed is tied to 0.
module approx_mult_error_accumulator #(
  parameter int W     = 32,
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     approx_prod,
  input  logic [W-1:0]     exact_prod,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [W-1:0]     max_ed
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] target;
  logic [W-1:0] ed;
  logic [ACC_W:0] sum_nx;
  logic accept, last, clear;

  assign accept = in_valid && in_ready;
  assign clear  = state == IDLE && start;
  assign last   = sample_cnt + CNT_W'(1) == target;
  assign ed     = exact_prod >= approx_prod ? exact_prod - approx_prod : approx_prod - exact_prod;
  // one extra bit catches the carry that triggers saturation
  assign sum_nx = {1'b0, sum_ed} + (ACC_W+1)'(ed);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (num_samples != '0 ? RUN : DONE) : IDLE;
      RUN:     state_nx = accept && last ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = state == RUN;
    busy     = state == RUN;
    done     = state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      target     <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
    end else if (clear) begin
      target     <= num_samples;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      err_cnt    <= err_cnt + CNT_W'(ed != '0);
      sum_ed     <= sum_nx[ACC_W] ? '1 : sum_nx[ACC_W-1:0];
    end

`ifdef ERR_MAX_TRACK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) max_ed <= '0;
    else if (clear) max_ed <= '0;
    else if (accept && ed > max_ed) max_ed <= ed;
`else
  assign max_ed = '0;
`endif
endmodule

// File: tb/tb_approx_mult_error_accumulator.sv
// tb_approx_mult_error_accumulator: randomized scoreboard bench; ACC_W=33 so saturation is reachable.
module tb_approx_mult_error_accumulator;
  localparam int W = 32, CNT_W = 16, ACC_W = 33;
  localparam longint SAT = (64'd1 << ACC_W) - 1;

  logic clk, rst_n, start, in_valid, in_ready, busy, done;
  logic [CNT_W-1:0] num_samples, sample_cnt, err_cnt;
  logic [W-1:0] approx_prod, exact_prod, max_ed;
  logic [ACC_W-1:0] sum_ed;

  approx_mult_error_accumulator #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .approx_prod(approx_prod),
    .exact_prod(exact_prod), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed)
  );

  typedef struct {int c; longint sc, ec, sum, mx;} exp_t;
  exp_t q[$];
  exp_t last_e;
  bit hold_pending;
  int cyc, checks, fails;
  bit qv[$];
  logic [W-1:0] qa[$], qe[$];

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void chk_results(string tag, exp_t e);
    chk({tag, "_sample_cnt"}, 64'(sample_cnt), e.sc);
    chk({tag, "_err_cnt"}, 64'(err_cnt), e.ec);
    chk({tag, "_sum_ed"}, 64'(sum_ed), e.sum);
`ifdef ERR_MAX_TRACK_EN
    chk({tag, "_max_ed"}, 64'(max_ed), e.mx);
`else
    chk({tag, "_max_ed"}, 64'(max_ed), 0);
`endif
  endfunction

  always @(negedge clk) if (rst_n) begin
    chk("ready_eq_busy", 64'(in_ready), 64'(busy));
    if (hold_pending && cyc == last_e.c + 1) begin
      chk_results("hold", last_e);
      hold_pending = 0;
    end
    if (done) begin
      chk("done_busy_low", 64'(busy | in_ready), 0);
      if (q.size() == 0) chk("done_unexpected", 64'(done), 0);
      else begin
        last_e = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(last_e.c));
        chk_results("done", last_e);
        hold_pending = 1;
      end
    end else if (q.size() != 0 && cyc > q[0].c) begin
      chk("done_seen", 64'(done), 1);
      void'(q.pop_front());
    end
  end

  function automatic void add(bit v, logic [W-1:0] a, logic [W-1:0] e);
    qv.push_back(v); qa.push_back(a); qe.push_back(e);
  endfunction

  function automatic void clear_pairs();
    qv.delete(); qa.delete(); qe.delete();
  endfunction

  // reference: the first n valid pairs presented after start are the run's samples
  task automatic run(input int n, input bit repulse);
    exp_t e;
    longint ed;
    e = '{c: 0, sc: 0, ec: 0, sum: 0, mx: 0};
    @(posedge clk); #1;
    start = 1; num_samples = CNT_W'(n);
    @(posedge clk); #1;
    start = 0; num_samples = CNT_W'($urandom);
    if (n == 0) begin
      e.c = cyc;
      q.push_back(e);
    end else
      foreach (qv[i]) begin
        in_valid = qv[i]; approx_prod = qa[i]; exact_prod = qe[i];
        start = repulse && i == 1;
        num_samples = CNT_W'($urandom);
        if (qv[i] && e.sc < n) begin
          ed = qe[i] >= qa[i] ? longint'(qe[i]) - longint'(qa[i]) : longint'(qa[i]) - longint'(qe[i]);
          e.sc++;
          e.ec += (ed != 0);
          e.sum = e.sum + ed > SAT ? SAT : e.sum + ed;
          e.mx = ed > e.mx ? ed : e.mx;
          if (e.sc == n) begin
            e.c = cyc + 1;
            q.push_back(e);
          end
        end
        @(posedge clk); #1;
        start = 0;
      end
    in_valid = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic rand_pairs(input int n);
    int got, mode;
    logic [W-1:0] a, d;
    bit v;
    clear_pairs();
    got = 0;
    while (got < n) begin
      v = $urandom_range(0, 9) < 7;
      mode = $urandom_range(0, 2);
      a = $urandom;
      d = $urandom_range(0, 300);
      add(v, a, mode == 0 ? a : mode == 1 ? (($urandom & 1) != 0 ? a + d : a - d) : W'($urandom));
      got += v;
    end
    repeat ($urandom_range(0, 2)) add(1, W'($urandom), W'($urandom));
  endtask

  initial begin
    int n;
    rst_n = 0; start = 0; in_valid = 0; num_samples = 0; approx_prod = 0; exact_prod = 0;
    #3;
    chk("reset_outputs", {in_ready, busy, done, sample_cnt, err_cnt}, 0);
    chk("reset_sum_max", {sum_ed, max_ed}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    clear_pairs();
    add(1, 100, 100); add(1, 90, 100); add(1, 130, 100); add(1, 7, 8);
    run(3, 0);

    clear_pairs();
    add(1, 10, 15); add(0, 0, 1000); add(0, 3, 2000); add(1, 20, 13); add(1, 0, 9);
    run(2, 0);

    clear_pairs();
    run(0, 0);

    rand_pairs(4);
    run(4, 1);

    clear_pairs();
    repeat (3) add(1, 0, 32'hFFFF_FFFF);
    run(3, 0);

    @(posedge clk); #1;
    start = 1; num_samples = 4;
    @(posedge clk); #1;
    start = 0; in_valid = 1; approx_prod = 1; exact_prod = 50;
    @(posedge clk); #1;
    in_valid = 0;
    chk("midrun_one_accepted", 64'(sample_cnt), 1);
    rst_n = 0;
    #1;
    chk("midrun_reset_ctrl", {in_ready, busy, done, sample_cnt, err_cnt}, 0);
    chk("midrun_reset_data", {sum_ed, max_ed}, 0);
    @(posedge clk); #1 rst_n = 1;
    rand_pairs(4);
    run(4, 0);

    repeat (40) begin
      n = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 12);
      rand_pairs(n);
      run(n, $urandom_range(0, 3) == 0);
    end
    repeat (4) @(posedge clk);
    chk("outstanding_done", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
